id_stage: RTL and testbench

Decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID register outputs, decodes the instruction and reads the register file. It produces the ID/EX pipeline register and drives the `hazard` stall and branch-squash behaviour back toward fetch. It also owns the register-file write port, which writeback drives.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/bancoRegistradores.sv | 45 ++++
 rtl/id_stage.sv | 154 +++++++++++++++
 tb/tb_id_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants and payload types for the MIPS decode stage.
// Contents: opcode and ALU-class constants, control bundle, ID/EX payload.
package mips_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [XLEN-1:0]   new_pc;
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   sign_ext;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } id_ex_t;

endpackage

// File: rtl/bancoRegistradores.sv
// 32x32 register file: two combinational read ports, one write port.
// Ports: clk, rst_n, read addresses/data (rs/rt), write enable/address/data.
// $0 always reads zero; a read of the register being written returns the
// incoming write data in the same cycle.
module bancoRegistradores
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_c_o,
  output logic [XLEN-1:0]   rdata2_c_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // Storage; $0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with write-through bypass.
  always_comb begin
    rdata1_c_o = regs_q[raddr1_i];
    rdata2_c_o = regs_q[raddr2_i];
    if (wr_en && (waddr_i == raddr1_i)) rdata1_c_o = wdata_i;
    if (wr_en && (waddr_i == raddr2_i)) rdata2_c_o = wdata_i;
    if (raddr1_i == '0) rdata1_c_o = '0;
    if (raddr2_i == '0) rdata2_c_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, register read, load-use hazard detection,
// branch squash and the ID/EX pipeline register.
// Ports: clk, reset (async active-low), IF/ID inputs, EX/MEM branch select,
// MEM/WB writeback port, combinational hazard, registered ID/EX outputs.
module id_stage
  import mips_pkg::*;
#(
  parameter bit NOP_ON_UNKNOWN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    IF_ID_instrSaida,
  input  logic [XLEN-1:0]    IF_ID_newPCout,
  input  logic               EX_MEM_select,
  input  logic               MEM_WB_regWrite,
  input  logic [REG_AW-1:0]  MEM_WB_writeReg,
  input  logic [XLEN-1:0]    MEM_WB_writeData,
  output logic               hazard,
  output logic [XLEN-1:0]    ID_EX_newPC,
  output logic [XLEN-1:0]    ID_EX_readData1,
  output logic [XLEN-1:0]    ID_EX_readData2,
  output logic [XLEN-1:0]    ID_EX_signExt,
  output logic [REG_AW-1:0]  ID_EX_rs,
  output logic [REG_AW-1:0]  ID_EX_rt,
  output logic [REG_AW-1:0]  ID_EX_rd,
  output logic               ID_EX_regDst,
  output logic               ID_EX_aluSrc,
  output logic               ID_EX_memRead,
  output logic               ID_EX_memWrite,
  output logic               ID_EX_memToReg,
  output logic               ID_EX_regWrite,
  output logic               ID_EX_branch,
  output logic [ALUOP_W-1:0] ID_EX_aluOp
);

  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rs_f, rt_f, rd_f;
  logic [XLEN-1:0]   rs_data, rt_data;
  ctrl_t             ctrl_dec;
  logic              uses_rt;
  logic              load_use;
  logic              squash;
  logic              squash_pending_q;
  id_ex_t            id_ex_q, id_ex_d;

  assign opcode = IF_ID_instrSaida[31:26];
  assign rs_f   = IF_ID_instrSaida[25:21];
  assign rt_f   = IF_ID_instrSaida[20:16];
  assign rd_f   = IF_ID_instrSaida[15:11];

  bancoRegistradores u_regs (
    .clk        (clk),
    .rst_n      (reset),
    .raddr1_i   (rs_f),
    .raddr2_i   (rt_f),
    .rdata1_c_o (rs_data),
    .rdata2_c_o (rt_data),
    .we_i       (MEM_WB_regWrite),
    .waddr_i    (MEM_WB_writeReg),
    .wdata_i    (MEM_WB_writeData)
  );

  // Main control decode; the all-zero word is a bubble.
  always_comb begin
    ctrl_dec = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        if (IF_ID_instrSaida != '0) begin
          ctrl_dec.reg_dst   = 1'b1;
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.alu_op    = ALUOP_FUNCT;
        end
      end
      OP_LW: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_ADD;
      end
      default: begin
        // With the bubble option off, unknown opcodes fall through as R-type.
        if (!NOP_ON_UNKNOWN) begin
          ctrl_dec.reg_dst   = 1'b1;
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.alu_op    = ALUOP_FUNCT;
        end
      end
    endcase
  end

  // Only R-type, sw and beq actually consume rt as a source.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign load_use = id_ex_q.ctrl.mem_read && (id_ex_q.rt != '0) &&
                    ((id_ex_q.rt == rs_f) || ((id_ex_q.rt == rt_f) && uses_rt));

  // A redirect or a dead wrong-path instruction must not freeze fetch.
  assign hazard = load_use && !EX_MEM_select && !squash_pending_q;
  assign squash = load_use || EX_MEM_select || squash_pending_q;

  // Next ID/EX contents; a bubble clears control only.
  always_comb begin
    id_ex_d            = '0;
    id_ex_d.new_pc     = IF_ID_newPCout;
    id_ex_d.read_data1 = rs_data;
    id_ex_d.read_data2 = rt_data;
    id_ex_d.sign_ext   = {{16{IF_ID_instrSaida[15]}}, IF_ID_instrSaida[15:0]};
    id_ex_d.rs         = rs_f;
    id_ex_d.rt         = rt_f;
    id_ex_d.rd         = rd_f;
    id_ex_d.ctrl       = squash ? CTRL_BUBBLE : ctrl_dec;
  end

  // ID/EX register and the one-cycle wrong-path kill flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q          <= '0;
      squash_pending_q <= 1'b0;
    end else begin
      id_ex_q          <= id_ex_d;
      squash_pending_q <= EX_MEM_select;
    end
  end

  assign ID_EX_newPC     = id_ex_q.new_pc;
  assign ID_EX_readData1 = id_ex_q.read_data1;
  assign ID_EX_readData2 = id_ex_q.read_data2;
  assign ID_EX_signExt   = id_ex_q.sign_ext;
  assign ID_EX_rs        = id_ex_q.rs;
  assign ID_EX_rt        = id_ex_q.rt;
  assign ID_EX_rd        = id_ex_q.rd;
  assign ID_EX_regDst    = id_ex_q.ctrl.reg_dst;
  assign ID_EX_aluSrc    = id_ex_q.ctrl.alu_src;
  assign ID_EX_memRead   = id_ex_q.ctrl.mem_read;
  assign ID_EX_memWrite  = id_ex_q.ctrl.mem_write;
  assign ID_EX_memToReg  = id_ex_q.ctrl.mem_to_reg;
  assign ID_EX_regWrite  = id_ex_q.ctrl.reg_write;
  assign ID_EX_branch    = id_ex_q.ctrl.branch;
  assign ID_EX_aluOp     = id_ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, all
// checked against a behavioural model of decode, register file and squash.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, newpc, wb_wd;
  logic        sel, wb_we;
  logic [4:0]  wb_wa;
  logic        hazard;
  logic [31:0] o_pc, o_rd1, o_rd2, o_sx;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_regdst, o_alusrc, o_memrd, o_memwr, o_memtoreg, o_regwr, o_branch;
  logic [1:0]  o_aluop;

  always #5 clk = ~clk;

  id_stage #(.NOP_ON_UNKNOWN(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_ID_instrSaida (instr),
    .IF_ID_newPCout   (newpc),
    .EX_MEM_select    (sel),
    .MEM_WB_regWrite  (wb_we),
    .MEM_WB_writeReg  (wb_wa),
    .MEM_WB_writeData (wb_wd),
    .hazard           (hazard),
    .ID_EX_newPC      (o_pc),
    .ID_EX_readData1  (o_rd1),
    .ID_EX_readData2  (o_rd2),
    .ID_EX_signExt    (o_sx),
    .ID_EX_rs         (o_rs),
    .ID_EX_rt         (o_rt),
    .ID_EX_rd         (o_rd),
    .ID_EX_regDst     (o_regdst),
    .ID_EX_aluSrc     (o_alusrc),
    .ID_EX_memRead    (o_memrd),
    .ID_EX_memWrite   (o_memwr),
    .ID_EX_memToReg   (o_memtoreg),
    .ID_EX_regWrite   (o_regwr),
    .ID_EX_branch     (o_branch),
    .ID_EX_aluOp      (o_aluop)
  );

  int errors = 0;
  int checks = 0;

  // Model state: architectural registers and expected ID/EX contents.
  logic [31:0] mregs [32];
  logic [31:0] e_pc, e_rd1, e_rd2, e_sx;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [8:0]  e_ctrl;   // regDst aluSrc memRead memWrite memToReg regWrite branch aluOp[1:0]
  logic        e_sq;
  logic        last_haz;

  function automatic logic [8:0] ctrl_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return (ins == 32'd0) ? 9'd0 : 9'b1_0_0_0_0_1_0_10;
      6'h23:   return 9'b0_1_1_0_1_1_0_00;
      6'h2B:   return 9'b0_1_0_1_0_0_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_0_0_1_0_00;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_wa == a) return wb_wd;
    return mregs[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_ctrl();
    return {o_regdst, o_alusrc, o_memrd, o_memwr, o_memtoreg, o_regwr, o_branch, o_aluop};
  endfunction

  task automatic check_outputs();
    chk("ctrl",   32'(dut_ctrl()), 32'(e_ctrl));
    chk("rd1",    o_rd1, e_rd1);
    chk("rd2",    o_rd2, e_rd2);
    chk("sext",   o_sx, e_sx);
    chk("newpc",  o_pc, e_pc);
    chk("fields", 32'({o_rs, o_rt, o_rd}), 32'({e_rs, e_rt, e_rd}));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    e_pc = 0; e_rd1 = 0; e_rd2 = 0; e_sx = 0;
    e_rs = 0; e_rt = 0; e_rd = 0; e_ctrl = 0; e_sq = 1'b0; last_haz = 1'b0;
  endtask

  // One pipeline cycle: inputs are already driven just after an edge.
  task automatic do_cycle();
    logic [5:0]  op;
    logic        uses_rt, raw, exp_h, kill;
    logic [31:0] n_rd1, n_rd2;
    #1;
    op      = instr[31:26];
    uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    raw     = e_ctrl[6] && (e_rt != 5'd0) &&
              ((e_rt == instr[25:21]) || ((e_rt == instr[20:16]) && uses_rt));
    exp_h   = raw && !sel && !e_sq;
    kill    = raw || sel || e_sq;
    chk("hazard", 32'(hazard), 32'(exp_h));
    n_rd1 = mread(instr[25:21]);
    n_rd2 = mread(instr[20:16]);
    @(posedge clk);
    if (wb_we && wb_wa != 5'd0) mregs[wb_wa] = wb_wd;
    e_pc = newpc; e_rd1 = n_rd1; e_rd2 = n_rd2;
    e_sx = {{16{instr[15]}}, instr[15:0]};
    e_rs = instr[25:21]; e_rt = instr[20:16]; e_rd = instr[15:11];
    e_ctrl = kill ? 9'd0 : ctrl_of(instr);
    e_sq = sel;
    last_haz = exp_h;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [31:0] ins, input logic s, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    instr = ins; sel = s; wb_we = we; wb_wa = wa; wb_wd = wd;
    newpc = newpc + 32'd4;
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ins;
    reset = 1'b0;
    instr = 0; newpc = 32'h0000_1000; sel = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
    model_reset();

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    chk("reset_hazard", 32'(hazard), 32'd0);
    reset = 1'b1;

    // Write $5 then decode add $3,$5,$0.
    drive(32'd0, 0, 1, 5'd5, 32'h1234_5678); do_cycle();
    drive(rtype(5'd5, 5'd0, 5'd3), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_add_rd1", o_rd1, 32'h1234_5678);
    chk("tp_add_rd2", o_rd2, 32'd0);
    chk("tp_add_ctrl", 32'({o_regdst, o_regwr, o_aluop}), 32'b1_1_10);

    // Same-cycle write-through into sw $7,4($2).
    drive(itype(6'h2B, 5'd2, 5'd7, 16'd4), 0, 1, 5'd7, 32'h0000_CAFE); do_cycle();
    chk("tp_sw_rd2", o_rd2, 32'h0000_CAFE);
    chk("tp_sw_sext", o_sx, 32'd4);
    chk("tp_sw_memwr", 32'(o_memwr), 32'd1);

    // Load-use: lw $4,0($1) then add $6,$4,$4.
    drive(itype(6'h23, 5'd1, 5'd4, 16'd0), 0, 0, 5'd0, 32'd0); do_cycle();
    drive(rtype(5'd4, 5'd4, 5'd6), 0, 0, 5'd0, 32'd0);
    #1 chk("tp_lu_hazard", 32'(hazard), 32'd1);
    do_cycle();
    chk("tp_lu_bubble", 32'(dut_ctrl()), 32'd0);
    newpc = newpc - 32'd4;
    drive(rtype(5'd4, 5'd4, 5'd6), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_lu_after", 32'(hazard), 32'd0);
    chk("tp_lu_add", 32'(dut_ctrl()), 32'b1_0_0_0_0_1_0_10);

    // Redirect concurrent with load-use.
    drive(itype(6'h23, 5'd1, 5'd4, 16'd0), 0, 0, 5'd0, 32'd0); do_cycle();
    drive(rtype(5'd4, 5'd4, 5'd6), 1, 0, 5'd0, 32'd0);
    #1 chk("tp_sel_hazard", 32'(hazard), 32'd0);
    do_cycle();
    chk("tp_sel_bubble1", 32'(dut_ctrl()), 32'd0);
    drive(itype(6'h08, 5'd3, 5'd3, 16'd1), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_sel_bubble2", 32'(dut_ctrl()), 32'd0);
    drive(rtype(5'd2, 5'd1, 5'd1), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_sel_normal", 32'(dut_ctrl()), 32'b1_0_0_0_0_1_0_10);

    // $0 write ignored; addi $1,$0,-1.
    drive(32'd0, 0, 1, 5'd0, 32'h0000_FFFF); do_cycle();
    drive(itype(6'h08, 5'd0, 5'd1, 16'hFFFF), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_addi_rd1", o_rd1, 32'd0);
    chk("tp_addi_sext", o_sx, 32'hFFFF_FFFF);

    // Unknown opcode.
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 0, 0, 5'd0, 32'd0); do_cycle();
    chk("tp_unknown", 32'(dut_ctrl()), 32'd0);

    // Reset asserted mid-squash, then normal decode after release.
    drive(itype(6'h23, 5'd5, 5'd3, 16'd8), 1, 0, 5'd0, 32'd0); do_cycle();
    drive(itype(6'h23, 5'd5, 5'd3, 16'd8), 0, 0, 5'd0, 32'd0);
    #1 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    chk("tp_rst_hazard", 32'(hazard), 32'd0);
    reset = 1'b1;
    do_cycle();
    chk("tp_rst_decode", 32'(dut_ctrl()), 32'b0_1_1_0_1_1_0_00);

    // Random traffic; fetch holds the instruction while a stall is reported.
    for (int n = 0; n < 400; n++) begin
      if (last_haz) begin
        ins = instr;
        newpc = newpc - 32'd4;
      end else begin
        case ($urandom_range(0, 7))
          0: op = 6'h00;
          1: op = 6'h23;
          2: op = 6'h2B;
          3: op = 6'h04;
          4: op = 6'h08;
          5: op = 6'h3F;
          6: op = 6'($urandom);
          default: op = 6'h23;
        endcase
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        if ($urandom_range(0, 19) == 0) ins = 32'd0;
      end
      drive(ins, ($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom);
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
